// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package ifetch_pkg;

    typedef enum logic {
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam int unsigned PC_STEP_DEF   = 4;
    localparam int unsigned ENTRY_ADDR_W  = 32;
    localparam int unsigned ENTRY_INSTR_W = 32;

    // One buffered fetch result at the default widths.
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0]  pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush beats push/pop.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: single-outstanding imem reads, buffered results,
// redirect flushes the buffer and squashes any in-flight response.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       PC_STEP   = PC_STEP_DEF,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               inst_ready,
    output logic [ADDR_W-1:0]  pc_cur
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    state_t                     state;
    logic [ADDR_W-1:0]          fetch_pc;
    logic                       squash;
    logic [CNT_W-1:0]           count;
    logic                       push;
    logic [ADDR_W+INSTR_W-1:0]  head;

    assign imem_req = !rst && (state == S_ISSUE) && (count < CNT_W'(BUF_DEPTH))
                      && !redirect_valid;
    assign push     = (state == S_WAIT) && imem_rvalid && !redirect_valid && !squash;

    assign imem_addr            = fetch_pc;
    assign pc_cur               = fetch_pc;
    assign inst_valid           = (count != '0);
    assign {inst_pc, inst_data} = head;

    ifetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (inst_valid && inst_ready),
        .push_data ({fetch_pc, imem_rdata}),
        .head_data (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_ISSUE;
            fetch_pc <= RESET_PC;
            squash   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            // A request still in flight must have its response discarded.
            if (state == S_WAIT && !imem_rvalid) begin
                squash <= 1'b1;
            end else begin
                squash <= 1'b0;
                state  <= S_ISSUE;
            end
        end else begin
            case (state)
                S_ISSUE: begin
                    if (imem_req) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!squash) begin
                            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                        end
                        squash <= 1'b0;
                        state  <= S_ISSUE;
                    end
                end
                default: state <= S_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit with a configurable-latency memory model.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc_cur;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
    } req_t;

    fetch_entry_t exp_q[$];
    req_t         req_log[$];
    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  cyc_n = 0;
    int unsigned  base = 0;
    int unsigned  lat_cfg = 1;
    int unsigned  lat_left = 0;
    logic [31:0]  pend_addr = '0;
    logic         mem_flush = 1'b0;

    ifetch_unit #(
        .ADDR_W    (32),
        .INSTR_W   (32),
        .RESET_PC  (32'h0),
        .PC_STEP   (4),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .pc_cur         (pc_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory: answers each request lat_cfg cycles later with 0xA000_0000|addr.
    initial begin
        logic        rq;
        logic [31:0] ra;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            rq = imem_req;
            ra = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (mem_flush) begin
                lat_left = 0;
            end else begin
                if (rq) begin
                    pend_addr = ra;
                    lat_left  = lat_cfg;
                end
                if (lat_left > 0) begin
                    if (lat_left == 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = 32'hA000_0000 | pend_addr;
                    end
                    lat_left--;
                end
            end
        end
    end

    // Output monitor: scoreboard pops on handshake, request log.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_pop", 64'(exp_q.size()), 64'd1);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check_eq("sb_pc", inst_pc, e.pc);
                check_eq("sb_data", inst_data, e.instr);
            end
        end
        if (imem_req) begin
            req_log.push_back('{cyc: cyc_n, addr: imem_addr});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic to_cycle(input int unsigned n);
        for (int unsigned k = 0; k < 200 && (cyc_n - base) < n; k++) cyc();
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, instr: 32'hA000_0000 | pc});
    endtask

    task automatic chk_req(input int unsigned idx, input int unsigned c, input logic [31:0] a);
        if (req_log.size() > idx) begin
            check_eq("req_cycle", 64'(req_log[idx].cyc - base), 64'(c));
            check_eq("req_addr", req_log[idx].addr, a);
        end else begin
            check_eq("req_missing", 64'(req_log.size()), 64'(idx + 1));
        end
    endtask

    task automatic do_reset(input logic rdy, input int unsigned lat);
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = rdy;
        mem_flush      = 1'b1;
        lat_cfg        = lat;
        cyc();
        mid();
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_pc_cur", pc_cur, 0);
        check_eq("rst_imem_addr", imem_addr, 0);
        check_eq("rst_inst_data", inst_data, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        cyc();
        mem_flush = 1'b0;
        exp_q.delete();
        req_log.delete();
        rst  = 1'b0;
        base = cyc_n;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;

        // Streaming, 1-cycle memory: one instruction every 2 cycles.
        do_reset(1'b1, 1);
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        to_cycle(7);
        chk_req(0, 0, 32'h0);
        chk_req(1, 2, 32'h4);
        chk_req(2, 4, 32'h8);

        // Backpressure: buffer fills, fetch stalls, then drains in order.
        do_reset(1'b0, 1);
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        to_cycle(6);
        mid();
        check_eq("stall_valid", inst_valid, 1);
        check_eq("stall_req", imem_req, 0);
        check_eq("stall_pc_cur", pc_cur, 32'h8);
        check_eq("stall_head_pc", inst_pc, 32'h0);
        check_eq("stall_head_data", inst_data, 32'hA000_0000);
        check_eq("stall_req_count", 64'(req_log.size()), 64'd2);
        to_cycle(7);
        inst_ready = 1'b1;
        to_cycle(11);
        chk_req(2, 8, 32'h8);

        // Latency 3, redirect while waiting: in-flight 0x8 squashed.
        do_reset(1'b1, 3);
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h100);
        to_cycle(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        to_cycle(11);
        redirect_valid = 1'b0;
        to_cycle(17);
        chk_req(2, 8, 32'h8);
        chk_req(3, 12, 32'h100);

        // Redirect coincident with rvalid: response dropped, refetch next cycle.
        do_reset(1'b1, 1);
        expect_pc(32'h0); expect_pc(32'h40);
        to_cycle(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        to_cycle(4);
        redirect_valid = 1'b0;
        to_cycle(7);
        chk_req(1, 2, 32'h4);
        chk_req(2, 4, 32'h40);

        // PC wrap at top of address space.
        do_reset(1'b1, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        to_cycle(1);
        redirect_valid = 1'b0;
        to_cycle(3);
        mid();
        check_eq("wrap_pc_cur", pc_cur, 32'h0);
        check_eq("wrap_imem_addr", imem_addr, 32'h0);
        chk_req(0, 1, 32'hFFFF_FFFC);
        to_cycle(6);

        // Redirect with a concurrent pop: whole buffer gone next cycle.
        do_reset(1'b0, 1);
        expect_pc(32'h0); expect_pc(32'h200);
        to_cycle(5);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        to_cycle(6);
        redirect_valid = 1'b0;
        mid();
        check_eq("flush_valid", inst_valid, 0);
        to_cycle(9);
        chk_req(2, 6, 32'h200);

        // Reset mid-operation; the stale response lands in S_ISSUE and is ignored.
        do_reset(1'b0, 3);
        to_cycle(6);
        rst = 1'b1;
        to_cycle(7);
        rst = 1'b0;
        mid();
        check_eq("mrst_valid", inst_valid, 0);
        check_eq("mrst_pc_cur", pc_cur, 32'h0);
        check_eq("mrst_req", imem_req, 1);
        check_eq("mrst_addr", imem_addr, 32'h0);
        check_eq("mrst_data", inst_data, 32'h0);
        expect_pc(32'h0);
        inst_ready = 1'b1;
        to_cycle(12);
        chk_req(2, 7, 32'h0);
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
